quantum_scheduler: RTL and testbench
====================================

// Module: quantum_scheduler
// PURPOSE
//  Preemptive time-slice scheduler feeding the processor core's context-switch path.
//  Counts executed Slow_Clock cycles of the running process and raises Preempt_Req when its
//  quantum expires. Selects the next runnable process ID round-robin and presents it on
//  Next_Proc_ID; the OS stub loads that ID into Data_1 and executes the context-change opcode.
//  Change_Context from the core acknowledges the request and restarts the quantum.
// PARAMETERS
//  NUM_PROC    4     number of process slots (fixed PC bases 0/512/1024/1536)
//  ID_W        2     width of process ID, = clog2(NUM_PROC)
//  QW          16    quantum counter width
//  QUANTUM     64    reset-time quantum in Slow_Clock cycles
//  ACK_TIMEOUT 256   cycles in REQ without ack before Sched_Err
// PORTS
//  Slow_Clock      in   1         processor clock; all state on rising edge
//  Raw_Reset_I     in   1         asynchronous active-low reset
//  Enable          in   1         scheduler on; 0 forces IDLE, outputs quiet
//  Proc_Active     in   NUM_PROC  bit i = process i runnable
//  Cur_Proc_ID     in   ID_W      Proc_ID currently executing (from core)
//  Halt            in   1         core halted/waiting on IO; freezes quantum count
//  Change_Context  in   1         core performed a context switch this cycle
//  Quantum_Load    in   1         1-cycle strobe: latch Quantum_Value
//  Quantum_Value   in   QW        new quantum; 0 is treated as 1
//  Preempt_Req     out  1         quantum expired, switch requested
//  Next_Proc_ID    out  ID_W      round-robin successor of Cur_Proc_ID
//  Tick_Count      out  QW        remaining cycles of current quantum
//  Switch_Count    out  32        total acknowledged context switches (wraps)
//  Sched_Err       out  1         sticky: request not acked within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE; Preempt_Req=0, Next_Proc_ID=0, Tick_Count=QUANTUM, Switch_Count=0,
//   Sched_Err=0, quantum register=QUANTUM, timeout counter=0. Reset mid-REQ drops request.
//  Next_Proc_ID (registered, 1-cycle latency): first i in Cur+1, Cur+2.. (mod NUM_PROC) with
//   Proc_Active[i]=1; if no other slot active, equals Cur_Proc_ID.
//  FSM:
//   IDLE: Enable=1 & Proc_Active!=0 -> RUN, Tick_Count <= quantum reg.
//   RUN : Tick_Count decrements by 1 per cycle when Halt=0; held when Halt=1.
//         Tick_Count==1 & decrementing: if another slot active -> REQ (Preempt_Req=1 next
//         cycle, Tick_Count=0); else reload quantum, stay RUN (no request).
//         Change_Context=1 (voluntary switch): reload quantum, Switch_Count+1, stay RUN.
//   REQ : Preempt_Req held 1; Tick_Count held 0; timeout counter increments.
//         Change_Context=1 -> RUN, Preempt_Req=0 next cycle, reload, Switch_Count+1,
//         timeout cleared. Timeout reaches ACK_TIMEOUT -> Sched_Err=1 (sticky until
//         reset), stay REQ. Proc_Active drops to only current slot -> RUN, reload, no count.
//   Any state: Enable=0 or Proc_Active==0 -> IDLE next cycle, Preempt_Req=0, count reload.
//  Quantum_Load: quantum reg updated same edge; applies at next reload, not to current count.
//   Simultaneous Quantum_Load and reload: the new value is used.
//  Change_Context same cycle as expiry: treated as ack; stay RUN, Switch_Count+1 once.
//  Switch_Count wraps 0xFFFFFFFF -> 0. Halt does not affect REQ timeout.
// TESTING
//  T1 QUANTUM=4, Active=1111, Cur=0, Halt=0 -> Preempt_Req=1 on 5th cycle after RUN entry,
//     Next_Proc_ID=1; pulse Change_Context -> Preempt_Req=0, Tick_Count=4, Switch_Count=1.
//  T2 Active=1010, Cur=3 -> Next_Proc_ID=1; Cur=1 -> Next_Proc_ID=3; Active=0001, Cur=0 ->
//     expiry reloads Tick_Count=4, Preempt_Req stays 0.
//  T3 Halt=1 for 10 cycles mid-quantum at Tick_Count=2 -> Tick_Count stays 2; resume -> request
//     2 cycles later.
//  T4 Hold REQ without ack, ACK_TIMEOUT=256 -> Sched_Err=1 at cycle 256, stays 1 after ack.
//  T5 Quantum_Load=1, Value=0 during RUN -> current count unaffected; next quantum length 1.
//  T6 Drop Raw_Reset_I while Preempt_Req=1 -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/quantum_scheduler.sv
// Preemptive time-slice scheduler: counts the running process's quantum, requests a context
// switch on expiry and offers the round-robin successor ID.
module quantum_scheduler #(
  parameter int unsigned NUM_PROC    = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned QW          = 16,
  parameter int unsigned QUANTUM     = 64,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic                Slow_Clock,
  input  logic                Raw_Reset_I,
  input  logic                Enable,
  input  logic [NUM_PROC-1:0] Proc_Active,
  input  logic [ID_W-1:0]     Cur_Proc_ID,
  input  logic                Halt,
  input  logic                Change_Context,
  input  logic                Quantum_Load,
  input  logic [QW-1:0]       Quantum_Value,
  output logic                Preempt_Req,
  output logic [ID_W-1:0]     Next_Proc_ID,
  output logic [QW-1:0]       Tick_Count,
  output logic [31:0]         Switch_Count,
  output logic                Sched_Err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StReq} state_e;

  state_e              state_q, state_d;
  logic [QW-1:0]       tick_q, tick_d;
  logic [QW-1:0]       quantum_q, quantum_d;
  logic [31:0]         switch_q, switch_d;
  logic                err_q, err_d;
  logic [TW-1:0]       tout_q, tout_d;
  logic [ID_W-1:0]     next_id_q, next_id_d;

  logic [NUM_PROC-1:0] cur_mask;
  logic                other_active;
  logic [QW-1:0]       load_val;
  logic [QW-1:0]       reload_val;

  assign cur_mask     = {{(NUM_PROC-1){1'b0}}, 1'b1} << Cur_Proc_ID;
  assign other_active = |(Proc_Active & ~cur_mask);

  // A zero quantum would never expire; clamp it to one cycle.
  assign load_val   = (Quantum_Value == '0) ? QW'(1) : Quantum_Value;
  assign quantum_d  = Quantum_Load ? load_val : quantum_q;
  assign reload_val = quantum_d;

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    next_id_d = Cur_Proc_ID;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i < NUM_PROC; i++) begin
      idx = ID_W'((int'(Cur_Proc_ID) + i) % NUM_PROC);
      if (!found && Proc_Active[idx]) begin
        next_id_d = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    switch_d = switch_q;
    err_d    = err_q;
    tout_d   = tout_q;
    if (!Enable || (Proc_Active == '0)) begin
      state_d = StIdle;
      tick_d  = reload_val;
      tout_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StRun;
          tick_d  = reload_val;
          tout_d  = '0;
        end
        StRun: begin
          // A voluntary switch wins over a simultaneous expiry and is counted once.
          if (Change_Context) begin
            tick_d   = reload_val;
            switch_d = switch_q + 32'd1;
          end else if (!Halt) begin
            if (tick_q <= QW'(1)) begin
              if (other_active) begin
                state_d = StReq;
                tick_d  = '0;
                tout_d  = '0;
              end else begin
                tick_d = reload_val;
              end
            end else begin
              tick_d = tick_q - QW'(1);
            end
          end
        end
        StReq: begin
          tick_d = '0;
          if (Change_Context) begin
            state_d  = StRun;
            tick_d   = reload_val;
            switch_d = switch_q + 32'd1;
            tout_d   = '0;
          end else if (!other_active) begin
            state_d = StRun;
            tick_d  = reload_val;
            tout_d  = '0;
          end else if (tout_q >= TW'(ACK_TIMEOUT - 1)) begin
            tout_d = TW'(ACK_TIMEOUT);
            err_d  = 1'b1;
          end else begin
            tout_d = tout_q + TW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Slow_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      state_q   <= StIdle;
      tick_q    <= QW'(QUANTUM);
      quantum_q <= QW'(QUANTUM);
      switch_q  <= '0;
      err_q     <= 1'b0;
      tout_q    <= '0;
      next_id_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      quantum_q <= quantum_d;
      switch_q  <= switch_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      next_id_q <= next_id_d;
    end
  end

  assign Preempt_Req  = (state_q == StReq);
  assign Next_Proc_ID = next_id_q;
  assign Tick_Count   = tick_q;
  assign Switch_Count = switch_q;
  assign Sched_Err    = err_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Bench for quantum_scheduler: successor-ID vector table plus quantum/request/timeout sequences.
module tb_quantum_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  active;
  logic [1:0]  cur;
  logic        halt;
  logic        cc;
  logic        qload;
  logic [15:0] qval;
  logic        preempt;
  logic [1:0]  next_id;
  logic [15:0] tick;
  logic [31:0] sw_cnt;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] active;
    logic [1:0] cur;
    logic [1:0] exp_next;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  quantum_scheduler #(
    .NUM_PROC   (4),
    .ID_W       (2),
    .QW         (16),
    .QUANTUM    (4),
    .ACK_TIMEOUT(256)
  ) dut (
    .Slow_Clock    (clk),
    .Raw_Reset_I   (rst_n),
    .Enable        (enable),
    .Proc_Active   (active),
    .Cur_Proc_ID   (cur),
    .Halt          (halt),
    .Change_Context(cc),
    .Quantum_Load  (qload),
    .Quantum_Value (qval),
    .Preempt_Req   (preempt),
    .Next_Proc_ID  (next_id),
    .Tick_Count    (tick),
    .Switch_Count  (sw_cnt),
    .Sched_Err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    active = 4'b0000;
    cur    = 2'd0;
    halt   = 1'b0;
    cc     = 1'b0;
    qload  = 1'b0;
    qval   = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_preempt", {31'd0, preempt}, 32'd0);
    check("rst_next", {30'd0, next_id}, 32'd0);
    check("rst_tick", {16'd0, tick}, 32'd4);
    check("rst_switch", sw_cnt, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Successor selection with the scheduler disabled so the FSM stays quiet.
    vecs.push_back('{4'b1111, 2'd0, 2'd1});
    vecs.push_back('{4'b1111, 2'd3, 2'd0});
    vecs.push_back('{4'b1010, 2'd3, 2'd1});
    vecs.push_back('{4'b1010, 2'd1, 2'd3});
    vecs.push_back('{4'b0001, 2'd0, 2'd0});
    vecs.push_back('{4'b0100, 2'd1, 2'd2});
    vecs.push_back('{4'b1000, 2'd3, 2'd3});
    vecs.push_back('{4'b0000, 2'd2, 2'd2});
    vecs.push_back('{4'b0110, 2'd2, 2'd1});
    vecs.push_back('{4'b1001, 2'd0, 2'd3});
    vecs.push_back('{4'b0011, 2'd1, 2'd0});
    foreach (vecs[i]) begin
      @(negedge clk);
      active = vecs[i].active;
      cur    = vecs[i].cur;
      exp_q.push_back({30'd0, vecs[i].exp_next});
      step();
      check($sformatf("next_id[%0d]", i), {30'd0, next_id}, exp_q.pop_front());
    end
    check("idle_preempt", {31'd0, preempt}, 32'd0);

    // Quantum 4 expiry with all slots runnable.
    @(negedge clk);
    active = 4'b1111;
    cur    = 2'd0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("run_tick%0d", k), {16'd0, tick}, 32'(4 - k));
      check($sformatf("run_nopre%0d", k), {31'd0, preempt}, 32'd0);
    end
    step();
    check("expire_preempt", {31'd0, preempt}, 32'd1);
    check("expire_tick", {16'd0, tick}, 32'd0);
    check("expire_next", {30'd0, next_id}, 32'd1);
    @(negedge clk);
    cc = 1'b1;
    step();
    check("ack_preempt", {31'd0, preempt}, 32'd0);
    check("ack_tick", {16'd0, tick}, 32'd4);
    check("ack_switch", sw_cnt, 32'd1);
    @(negedge clk);
    cc     = 1'b0;
    active = 4'b0001;
    // Only the current slot runnable: expiry reloads without a request.
    repeat (4) step();
    check("solo_tick", {16'd0, tick}, 32'd4);
    check("solo_preempt", {31'd0, preempt}, 32'd0);

    // Halt freezes the quantum.
    @(negedge clk);
    active = 4'b1111;
    repeat (2) step();
    check("pre_halt_tick", {16'd0, tick}, 32'd2);
    @(negedge clk);
    halt = 1'b1;
    repeat (10) step();
    check("halt_tick", {16'd0, tick}, 32'd2);
    @(negedge clk);
    halt = 1'b0;
    step();
    check("resume_nopre", {31'd0, preempt}, 32'd0);
    step();
    check("resume_preempt", {31'd0, preempt}, 32'd1);

    // Unacknowledged request times out after 256 cycles.
    repeat (255) step();
    check("tout_err_early", {31'd0, err}, 32'd0);
    step();
    check("tout_err", {31'd0, err}, 32'd1);
    check("tout_preempt", {31'd0, preempt}, 32'd1);
    @(negedge clk);
    cc = 1'b1;
    step();
    check("tout_ack_preempt", {31'd0, preempt}, 32'd0);
    check("tout_ack_switch", sw_cnt, 32'd2);
    check("tout_err_sticky", {31'd0, err}, 32'd1);

    // Zero quantum load: current count unaffected, next quantum is one cycle.
    @(negedge clk);
    cc    = 1'b0;
    qload = 1'b1;
    qval  = 16'd0;
    step();
    check("qload_tick", {16'd0, tick}, 32'd3);
    @(negedge clk);
    qload = 1'b0;
    repeat (3) step();
    check("qload_expire", {31'd0, preempt}, 32'd1);
    @(negedge clk);
    cc = 1'b1;
    step();
    check("q1_tick", {16'd0, tick}, 32'd1);
    check("q1_switch", sw_cnt, 32'd3);
    @(negedge clk);
    cc = 1'b0;
    step();
    check("q1_preempt", {31'd0, preempt}, 32'd1);

    // Asynchronous reset while a request is pending.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_preempt", {31'd0, preempt}, 32'd0);
    check("async_tick", {16'd0, tick}, 32'd4);
    check("async_switch", sw_cnt, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    check("async_next", {30'd0, next_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
